program_sequencer: RTL

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// Program index sequencer with INC/JUMP/CALL/RET ops, a LIFO return stack and sticky overflow/underflow flags.
// Optional build macro PROGRAM_SEQUENCER_WRAP_EN makes INC at LIMIT wrap to 0 instead of saturating.
module program_sequencer #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] LIMIT       = 16'hBFFF,
  parameter int               STACK_DEPTH = 4,
  localparam int              DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] index,
  output logic [DW-1:0]    depth,
  output logic             atLimit,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JUMP = 3'b001,
    OP_CALL = 3'b010,
    OP_RET  = 3'b011
  } op_e;

  logic [WIDTH-1:0] index_q, index_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] inc_val, jump_val;
  logic             push;
  logic             stack_full, stack_empty;
  logic [AW-1:0]    push_ptr, top_ptr;
  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  assign stack_full  = (depth_q == DW'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  // depth never exceeds STACK_DEPTH <= 2**AW, so AW-bit arithmetic on the pointer is exact.
  assign push_ptr    = depth_q[AW-1:0];
  assign top_ptr     = push_ptr - 1'b1;

  // Successor of the current index; also the return address pushed by CALL.
  always_comb begin
    inc_val = index_q + 1'b1;
    if (index_q >= LIMIT) begin
`ifdef PROGRAM_SEQUENCER_WRAP_EN
      inc_val = '0;
`else
      inc_val = LIMIT;
`endif
    end
  end

  assign jump_val = (target > LIMIT) ? LIMIT : target;

  always_comb begin
    index_d = index_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (enable) begin
      case (op)
        OP_INC:  index_d = inc_val;
        OP_JUMP: index_d = jump_val;
        OP_CALL: begin
          if (stack_full) begin
            ovf_d = 1'b1;
          end else begin
            push    = 1'b1;
            index_d = jump_val;
            depth_d = depth_q + 1'b1;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            unf_d = 1'b1;
          end else begin
            index_d = stack_mem[top_ptr];
            depth_d = depth_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      index_q <= index_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset: clearing depth makes old entries unreachable.
  always_ff @(posedge clock) begin
    if (push) stack_mem[push_ptr] <= inc_val;
  end

  assign index     = index_q;
  assign depth     = depth_q;
  assign atLimit   = (index_q == LIMIT);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
